mystic_main_mem_tx: RTL and testbench

MYSTIC_MAIN_MEM_TX -- requirements
Module: mystic_main_mem_tx

---
 rtl/mystic_mem_pkg.sv | 19 +
 rtl/mystic_uart_ser.sv | 71 +++++++
 rtl/mystic_main_mem_tx.sv | 87 ++++++++
 tb/tb_mystic_main_mem_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mystic_mem_pkg.sv
// Shared types and constants for the main-memory UART dump block.
package mystic_mem_pkg;

  localparam int unsigned AddrWDefault = 18;

  // 8N1 framing: one start bit, eight data bits, one stop bit.
  localparam int unsigned DataBits  = 8;
  localparam int unsigned StopBits  = 1;
  localparam int unsigned FrameBits = 1 + DataBits + StopBits;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/mystic_uart_ser.sv
// Byte serializer: start bit, LSB-first data, stop bit, each held baud_div clocks.
module mystic_uart_ser
  import mystic_mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] baud_div,
  input  logic        load,
  input  logic [7:0]  tx_byte,
  output logic        tx_o,
  output logic        frame_done
);

  logic        active_q;
  logic [3:0]  bit_idx_q;
  logic [15:0] cnt_q;
  logic [15:0] div_q;
  logic [7:0]  shift_q;
  logic [15:0] div_eff;
  logic        bit_end;
  logic        last_bit;

  assign div_eff    = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign bit_end    = active_q && (cnt_q == div_q - 16'd1);
  assign last_bit   = (bit_idx_q == 4'(FrameBits - 1));
  assign frame_done = bit_end && last_bit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      bit_idx_q <= 4'd0;
      cnt_q     <= 16'd0;
      div_q     <= 16'd1;
      shift_q   <= 8'd0;
    end else if (load) begin
      active_q  <= 1'b1;
      bit_idx_q <= 4'd0;
      cnt_q     <= 16'd0;
      div_q     <= div_eff;
      shift_q   <= tx_byte;
    end else if (active_q) begin
      if (bit_end) begin
        cnt_q <= 16'd0;
        // Divider is re-sampled only at bit boundaries.
        div_q <= div_eff;
        if (last_bit) begin
          active_q <= 1'b0;
        end else begin
          bit_idx_q <= bit_idx_q + 4'd1;
          if (bit_idx_q != 4'd0) begin
            shift_q <= shift_q >> 1;
          end
        end
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    tx_o = 1'b1;
    if (active_q) begin
      if (bit_idx_q == 4'd0) begin
        tx_o = 1'b0;
      end else if (bit_idx_q <= 4'(DataBits)) begin
        tx_o = shift_q[0];
      end
    end
  end

endmodule

// File: rtl/mystic_main_mem_tx.sv
// Reads a block of main memory byte by byte and streams it out as 8N1 UART frames.
module mystic_main_mem_tx
  import mystic_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] length_i,
  input  logic [15:0]       baud_div,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              disable_core_n
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              ser_load;
  logic              frame_done;

  mystic_uart_ser u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .baud_div   (baud_div),
    .load       (ser_load),
    .tx_byte    (mem_rdata_i),
    .tx_o       (tx_o),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    ser_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = start_addr_i;
          rem_d   = length_i;
          state_d = (length_i == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        // Read data is valid now, one cycle after the FETCH read strobe.
        ser_load = 1'b1;
        state_d  = StSend;
      end
      StSend: begin
        if (frame_done) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          state_d = (rem_q == ADDR_W'(1)) ? StDone : StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr_o     = addr_q;
  assign mem_re_o       = (state_q == StFetch);
  assign busy_o         = (state_q == StFetch) || (state_q == StLatch) || (state_q == StSend);
  assign done_o         = (state_q == StDone);
  assign disable_core_n = ~busy_o;

endmodule

// File: tb/tb_mystic_main_mem_tx.sv
// Self-checking bench: scoreboarded reads and decoded UART frames for table and corner cases.
module tb_mystic_main_mem_tx;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] length = '0;
  logic [15:0]   baud_div = 16'd4;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [7:0]    mem_rdata = 8'h00;
  logic          tx;
  logic          busy;
  logic          done;
  logic          disable_core_n;

  int errors = 0;
  int checks = 0;
  int inv_err = 0;
  int bd = 4;

  logic [AW-1:0] exp_addr[$];
  logic [7:0]    exp_byte[$];

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    int            baud;
  } dump_t;

  dump_t vec[4];

  mystic_main_mem_tx #(.ADDR_W(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .start_addr_i   (start_addr),
    .length_i       (length),
    .baud_div       (baud_div),
    .mem_addr_o     (mem_addr),
    .mem_re_o       (mem_re),
    .mem_rdata_i    (mem_rdata),
    .tx_o           (tx),
    .busy_o         (busy),
    .done_o         (done),
    .disable_core_n (disable_core_n)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(logic [AW-1:0] a);
    case (a)
      18'h00010: return 8'hAB;
      18'h00011: return 8'hCD;
      18'h00012: return 8'h12;
      18'h00013: return 8'h34;
      default:   return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory with one-cycle read latency.
  always @(posedge clk) if (mem_re) mem_rdata <= model(mem_addr);

  always @(negedge clk) begin
    if (!rst && mem_re) begin
      if (exp_addr.size() == 0) check("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
      else check("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
    if (disable_core_n != !busy || (done && busy) || (!busy && !tx)) inv_err++;
  end

  // UART decoder sampling mid-bit on the falling edge.
  logic       dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;
  always @(negedge clk) begin
    int be, idx, ph;
    be = (bd == 0) ? 1 : bd;
    if (rst) begin
      dec_active = 1'b0;
    end else begin
      if (!dec_active) begin
        if (!tx) begin
          dec_active = 1'b1;
          dec_cnt = 0;
        end
      end else begin
        dec_cnt++;
      end
      if (dec_active) begin
        idx = dec_cnt / be;
        ph  = dec_cnt % be;
        if (ph == be / 2) begin
          if (idx == 0) check("start_bit", 32'(tx), 32'd0);
          else if (idx <= 8) dec_byte[idx-1] = tx;
          else begin
            check("stop_bit", 32'(tx), 32'd1);
            if (exp_byte.size() == 0) check("unexpected_frame", 32'(dec_byte), 32'hFFFF_FFFF);
            else check("tx_byte", 32'(dec_byte), 32'(exp_byte.pop_front()));
            dec_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic expect_dump(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = addr + AW'(i);
      exp_addr.push_back(a);
      exp_byte.push_back(model(a));
    end
  endtask

  task automatic drive_start(input logic [AW-1:0] addr, input int len, input int bdv);
    bd         = bdv;
    baud_div   = 16'(bdv);
    start_addr = addr;
    length     = AW'(len);
    start      = 1'b1;
  endtask

  task automatic run_dump(input logic [AW-1:0] addr, input int len, input int bdv,
                          input int poke_at, input bit poke_done);
    int be, budget, dones;
    be = (bdv == 0) ? 1 : bdv;
    budget = len * (10 * be + 2) + 12;
    dones = 0;
    expect_dump(addr, len);
    @(negedge clk);
    drive_start(addr, len, bdv);
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == poke_at) begin
        start_addr = '0;
        length     = AW'(7);
        start      = 1'b1;
      end
      if (done) begin
        dones++;
        if (poke_done) start = 1'b1;
      end
    end
    start = 1'b0;
    check("done_pulses", 32'(dones), 32'd1);
    check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    check("byte_queue_drained", 32'(exp_byte.size()), 32'd0);
    check("idle_after_dump", 32'({busy, tx, disable_core_n}), 32'b011);
  endtask

  initial begin
    int first_low, done_at, busy_n, re_n, low_n, dones;

    vec[0] = '{addr: 18'h00010, len: 4, baud: 4};
    vec[1] = '{addr: 18'h3FFFE, len: 3, baud: 2};
    vec[2] = '{addr: 18'h00100, len: 2, baud: 0};
    vec[3] = '{addr: 18'h12345, len: 3, baud: 7};

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({tx, mem_re, busy, done, disable_core_n}), 32'b10001);
    check("reset_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) run_dump(vec[v].addr, vec[v].len, vec[v].baud, 0, 1'b0);

    // Latency: start bit three cycles after start is sampled, done right after the stop bit.
    expect_dump(18'h00020, 1);
    @(negedge clk);
    drive_start(18'h00020, 1, 4);
    first_low = -1;
    done_at = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (!tx && first_low < 0) first_low = i;
      if (done && done_at < 0) done_at = i;
    end
    check("start_bit_latency", 32'(first_low), 32'd3);
    check("done_latency", 32'(done_at), 32'd43);

    // Zero length: straight to DONE, no reads, line stays idle.
    @(negedge clk);
    drive_start(18'h00040, 0, 4);
    busy_n = 0; re_n = 0; low_n = 0; done_at = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (mem_re) re_n++;
      if (!tx) low_n++;
      if (done && done_at < 0) done_at = i;
    end
    check("len0_done", 32'(done_at), 32'd1);
    check("len0_busy_cycles", 32'(busy_n), 32'd0);
    check("len0_reads", 32'(re_n), 32'd0);
    check("len0_tx_low", 32'(low_n), 32'd0);

    // Restart mid-dump and during DONE must both be ignored.
    run_dump(18'h00400, 3, 2, 30, 1'b1);

    // Reset during the data bits of byte 2 of 5.
    expect_dump(18'h00200, 5);
    @(negedge clk);
    drive_start(18'h00200, 5, 4);
    dones = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dones++;
    end
    rst = 1'b1;
    #1;
    check("abort_outputs", 32'({tx, busy, disable_core_n, mem_re}), 32'b1010);
    check("abort_bytes_left", 32'(exp_byte.size()), 32'd4);
    exp_addr.delete();
    exp_byte.delete();
    @(negedge clk);
    if (done) dones++;
    check("abort_no_done", 32'(dones), 32'd0);
    rst = 1'b0;
    run_dump(18'h00300, 2, 3, 0, 1'b0);

    check("invariants", 32'(inv_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
